// File: rtl/eh2_lsu_mmio_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eh2_lsu_mmio_resp_pkg
// Purpose  : Shared types and constants for the LSU MMIO responder.
//            - eh2_mmio_rsp_t : payload of one queued response
//            - MSCAUSE_*      : error cause codes, identical to the LSU fault
//                               encoding so the LSU can forward them unchanged
// Revision : 1.0 - initial release
// ============================================================================
package eh2_lsu_mmio_resp_pkg;

  localparam logic [3:0] MSCAUSE_NONE     = 4'h0;
  localparam logic [3:0] MSCAUSE_UNMAPPED = 4'h2;
  localparam logic [3:0] MSCAUSE_ILLEGAL  = 4'h6;

  // The response tag travels next to this payload in the queue because its
  // width is a per-instance parameter and cannot live in a package type.
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  mscause;
  } eh2_mmio_rsp_t;

endpackage : eh2_lsu_mmio_resp_pkg
`default_nettype wire

// File: rtl/eh2_lsu_mmio_rspq.sv
`default_nettype none
// ============================================================================
// Module   : eh2_lsu_mmio_rspq
// Purpose  : In-order response queue of DEPTH entries for the MMIO responder.
//            The head entry drives the outputs directly, so they hold steady
//            while the consumer stalls.
// Ports    : clk, rst_l        - clock, asynchronous active-low reset
//            scan_mode         - forces the local clock enables on
//            push, push_rsp,
//            push_tag          - enqueue one response (never while full)
//            pop_ready         - consumer accepts the head this cycle
//            full, valid       - queue state
//            head_rsp, head_tag- head entry
// Revision : 1.0 - initial release
// ============================================================================
module eh2_lsu_mmio_rspq
  import eh2_lsu_mmio_resp_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int TAG_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic                 scan_mode,
  input  logic                 push,
  input  eh2_mmio_rsp_t        push_rsp,
  input  logic [TAG_WIDTH-1:0] push_tag,
  input  logic                 pop_ready,
  output logic                 full,
  output logic                 valid,
  output eh2_mmio_rsp_t        head_rsp,
  output logic [TAG_WIDTH-1:0] head_tag
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  eh2_mmio_rsp_t        r_mem     [DEPTH];
  logic [TAG_WIDTH-1:0] r_tag_mem [DEPTH];
  logic [PTR_W-1:0]     r_wp;
  logic [PTR_W-1:0]     r_rp;
  logic [CNT_W-1:0]     r_count;

  logic w_pop;
  logic w_clken;

  assign valid   = (r_count != '0);
  assign full    = (r_count == CNT_W'(DEPTH));
  assign w_pop   = valid & pop_ready;
  // Queue state only moves on push or pop; scan forces the enable on.
  assign w_clken = push | w_pop | scan_mode;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i]     <= '0;
        r_tag_mem[i] <= '0;
      end
    end else if (w_clken) begin
      if (push) begin
        r_mem[r_wp]     <= push_rsp;
        r_tag_mem[r_wp] <= push_tag;
        // DEPTH is a power of two, so the pointer wraps on overflow.
        r_wp            <= r_wp + PTR_W'(1);
      end
      if (w_pop) begin
        r_rp <= r_rp + PTR_W'(1);
      end
      if (push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!push && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  assign head_rsp = r_mem[r_rp];
  assign head_tag = r_tag_mem[r_rp];

endmodule : eh2_lsu_mmio_rspq
`default_nettype wire

// File: rtl/eh2_lsu_mmio_resp.sv
`default_nettype none
// ============================================================================
// Module   : eh2_lsu_mmio_resp
// Purpose  : Target-side responder for word MMIO register accesses from the
//            LSU. Decodes the window, performs the register access at the
//            accept edge and returns an in-order tagged response.
// Ports    : clk, rst_l            - clock, asynchronous active-low reset
//            req_valid/req_ready   - request handshake
//            req_write, req_addr,
//            req_size, req_wdata,
//            req_tag               - request fields
//            rsp_valid/rsp_ready   - response handshake
//            rsp_rdata, rsp_err,
//            rsp_mscause, rsp_tag  - response fields (queue head)
//            busy                  - responses outstanding
//            scan_mode             - clock-enable override
// Revision : 1.0 - initial release
// ============================================================================
module eh2_lsu_mmio_resp
  import eh2_lsu_mmio_resp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'hf00c_0000,
  parameter int          NUM_REGS   = 16,
  parameter int          RESP_DEPTH = 2,
  parameter int          TAG_WIDTH  = 3,
  parameter logic [31:0] ID_VALUE   = 32'h0000_0E12
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [31:0]          req_addr,
  input  logic [1:0]           req_size,
  input  logic [31:0]          req_wdata,
  input  logic [TAG_WIDTH-1:0] req_tag,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic [3:0]           rsp_mscause,
  output logic [TAG_WIDTH-1:0] rsp_tag,
  output logic                 busy,
  input  logic                 scan_mode
);

  localparam int          IDX_W    = $clog2(NUM_REGS);
  localparam logic [31:0] WIN_SIZE = 32'(4 * NUM_REGS);
  localparam logic [31:0] WIN_MASK = ~(WIN_SIZE - 32'd1);

  logic [31:0]      r_regs [NUM_REGS];
  logic             r_out_of_reset;

  logic             w_accept;
  logic             w_full;
  logic             w_in_win;
  logic             w_unmapped;
  logic             w_illegal;
  logic             w_err;
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_rd_val;
  logic             w_wr_en;
  logic             w_reg_clken;
  eh2_mmio_rsp_t    w_push_rsp;
  eh2_mmio_rsp_t    w_head_rsp;

  // Holds req_ready low while reset is asserted; the queue itself would
  // otherwise look empty and advertise space.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_out_of_reset <= 1'b0;
    end else begin
      r_out_of_reset <= 1'b1;
    end
  end

  // No look-ahead on a same-cycle pop: a full queue stalls for one cycle.
  assign req_ready = r_out_of_reset & ~w_full;
  assign w_accept  = req_valid & req_ready;

  // Address decode
  assign w_in_win   = ((req_addr & WIN_MASK) == BASE_ADDR);
  assign w_idx      = req_addr[IDX_W+1:2];
  assign w_unmapped = ~w_in_win;
  assign w_illegal  = w_in_win & ((req_size != 2'd2) | (req_addr[1:0] != 2'b00));
  assign w_err      = w_unmapped | w_illegal;

  // Register 0 is the read-only ID; its array slot is never written.
  assign w_rd_val    = (w_idx == '0) ? ID_VALUE : r_regs[w_idx];
  assign w_wr_en     = w_accept & req_write & ~w_err & (w_idx != '0);
  assign w_reg_clken = w_wr_en | scan_mode;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_reg_clken) begin
      if (w_wr_en) begin
        r_regs[w_idx] <= req_wdata;
      end
    end
  end

  // Response build: unmapped takes priority over illegal.
  always_comb begin
    w_push_rsp         = '0;
    w_push_rsp.err     = w_err;
    w_push_rsp.mscause = w_unmapped ? MSCAUSE_UNMAPPED :
                         w_illegal  ? MSCAUSE_ILLEGAL  : MSCAUSE_NONE;
    w_push_rsp.rdata   = (!w_err && !req_write) ? w_rd_val : 32'd0;
  end

  eh2_lsu_mmio_rspq #(
    .DEPTH     (RESP_DEPTH),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_rspq (
    .clk       (clk),
    .rst_l     (rst_l),
    .scan_mode (scan_mode),
    .push      (w_accept),
    .push_rsp  (w_push_rsp),
    .push_tag  (req_tag),
    .pop_ready (rsp_ready),
    .full      (w_full),
    .valid     (rsp_valid),
    .head_rsp  (w_head_rsp),
    .head_tag  (rsp_tag)
  );

  assign busy        = rsp_valid;
  assign rsp_rdata   = w_head_rsp.rdata;
  assign rsp_err     = w_head_rsp.err;
  assign rsp_mscause = w_head_rsp.mscause;

endmodule : eh2_lsu_mmio_resp
`default_nettype wire

// File: doc/eh2_lsu_mmio_resp.md
Name: eh2_lsu_mmio_resp

Overview:
Target-side responder for word-oriented memory-mapped register accesses issued by the LSU, such as the PIC and core-local MMIO windows. It accepts one request per cycle over a valid/ready handshake and decodes the address against its window. It performs the register read or write and returns an in-order tagged response through a small response queue. Unmapped and illegal accesses get error responses whose mscause codes match the LSU fault encoding.

Parameters:
BASE_ADDR, 32'hf00c_0000, byte address of register 0; aligned to 4*NUM_REGS.
NUM_REGS, 16, number of 32-bit registers; power of two, 2..64.
RESP_DEPTH, 2, response queue entries; power of two, >=2.
TAG_WIDTH, 3, request/response tag width.
ID_VALUE, 32'h0000_0E12, read-only contents of register 0.

Ports:
clk  in  1  core clock
rst_l  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  request can be accepted
req_write  in  1  1=store, 0=load
req_addr  in  32  byte address
req_size  in  2  0=byte, 1=half, 2=word, 3=reserved
req_wdata  in  32  store data
req_tag  in  TAG_WIDTH  returned unchanged in the response
rsp_valid  out  1  response at queue head
rsp_ready  in  1  consumer takes the response
rsp_rdata  out  32  load data; 0 for stores and errors
rsp_err  out  1  access error
rsp_mscause  out  4  error cause; 0 when no error
rsp_tag  out  TAG_WIDTH  tag of the response
busy  out  1  queue non-empty
scan_mode  in  1  clock-gating override only

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-low on rst_l.
- Reset clears:
  - queue count and pointers (queue empty);
  - all registers 1..NUM_REGS-1 to 0;
  - rsp_valid=0, busy=0, rsp_err=0, rsp_mscause=0, rsp_rdata=0, rsp_tag=0.
  - req_ready=1 from the first cycle after reset.
- Accept condition: accept = req_valid & req_ready. req_ready = (count != RESP_DEPTH). req_ready does not look ahead to a same-cycle pop, so a full queue always stalls for one cycle.
- Decode, evaluated on accept:
  - in_win = (req_addr & ~(4*NUM_REGS-1)) == BASE_ADDR.
  - idx = req_addr[log2(NUM_REGS)+1:2].
  - unmapped = ~in_win, giving mscause 4'h2.
  - illegal = in_win & ((req_size != 2) | (req_addr[1:0] != 0)), giving mscause 4'h6.
  - Priority: unmapped over illegal.
- Load with no error: rdata = (idx==0) ? ID_VALUE : reg[idx]. The value is sampled at accept, so it reflects every previously accepted store.
- Store with no error: reg[idx] <= req_wdata at the accept edge. A store to idx 0 is silently ignored with no error. The store response returns rdata 0.
- Any error: no register changes; response rdata=0, err=1.
- Latency: an accepted request's response is visible at the queue head no earlier than the next cycle. With an empty queue it is exactly one cycle.
- Queue behaviour:
  - Strictly FIFO order. Pop = rsp_valid & rsp_ready.
  - Write and read pointers wrap modulo RESP_DEPTH.
  - Push and pop in the same cycle leave count unchanged; this is only possible when 0 < count < RESP_DEPTH.
  - Output ports are driven directly from the head entry. They hold stable while rsp_valid=1 and rsp_ready=0.
  - rsp_valid = busy = (count != 0).
- Reset mid-operation discards all queued responses. Register contents return to 0.
- req_size=3 is always illegal inside the window.
- Tags are never checked; duplicate tags are legal.

Decomposition:
- eh2_pkg additions:
  - typedef eh2_mmio_rsp_t {rdata[31:0], err, mscause[3:0], tag};
  - localparams MSCAUSE_UNMAPPED=4'h2 and MSCAUSE_ILLEGAL=4'h6, shared with LSU fault encoding.
- Sub-module eh2_lsu_mmio_rspq holds the RESP_DEPTH-entry FIFO of eh2_mmio_rsp_t, including count, pointers and full/empty. The top level holds decode, the register file and the handshake.
- Flops use rvdff/rvdffe with clock gating enabled by accept and by pop.

Test Plan:
1. Reset then load from BASE_ADDR+0, tag 5 -> next cycle rsp_valid=1, rdata=32'h0000_0E12, err=0, mscause=0, tag=5.
2. Store 32'hDEAD_BEEF to BASE+0x8, then load BASE+0x8 on back-to-back cycles with rsp_ready=1 -> load rdata=32'hDEAD_BEEF. A store to BASE+0x0 followed by a load still returns ID_VALUE.
3. Load BASE+0x40 (out of window, NUM_REGS=16) -> err=1, mscause=2, rdata=0. A halfword load at BASE+0x4 and a word load at BASE+0x6 -> err=1, mscause=6, registers unchanged.
4. Hold rsp_ready=0 and issue 3 requests -> first two accepted, req_ready=0 on the third. The head is held stable. Raise rsp_ready for one cycle -> the third request is accepted the following cycle, and responses come out in tag order.
5. With count=1, push and pop in the same cycle for 8 consecutive cycles -> count stays 1, pointers wrap, and no response is lost or duplicated.
6. Assert rst_l=0 with 2 responses queued and reg[3]=32'h1234 -> rsp_valid=0 and req_ready=0 while in reset. After release, req_ready=1, and a load of BASE+0xC returns 0.
